// File: rtl/input_debounce4.sv
// Four-channel switch debouncer: each raw level is synchronized, then must differ
// from its debounced output for STABLE_CNT consecutive edges before the output follows.
module input_debounce4 #(
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a1_raw,
  input  logic b1_raw,
  input  logic a2_raw,
  input  logic b2_raw,
  output logic a1,
  output logic b1,
  output logic a2,
  output logic b2,
  output logic changed,
  output logic settled
);

  localparam logic [7:0] CNT_LAST    = 8'(STABLE_CNT - 1);
  localparam logic [8:0] SETTLE_LAST = 9'(STABLE_CNT + 1);

  typedef enum logic {
    STABLE   = 1'b0,
    CHANGING = 1'b1
  } state_e;

  logic [3:0]      raw;
  logic [3:0]      sync0, sync1;
  logic [3:0]      out_q, out_d;
  logic [3:0][7:0] cnt_q, cnt_d;
  state_e          state_q [4];
  state_e          state_d [4];
  logic            changed_q;
  logic            settled_q;
  logic [8:0]      start_cnt_q;

  assign raw = {b2_raw, a2_raw, b1_raw, a1_raw};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
    end
  end

  // Per-channel state register; the counter only ever holds 0..STABLE_CNT-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < 4; i++) state_q[i] <= STABLE;
    end else begin
      out_q <= out_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < 4; i++) state_q[i] <= state_d[i];
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    out_d = out_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        STABLE: begin
          cnt_d[i] = '0;
          if (sync1[i] != out_q[i]) begin
            if (CNT_LAST == 8'd0) begin
              out_d[i] = sync1[i];
            end else begin
              cnt_d[i]   = 8'd1;
              state_d[i] = CHANGING;
            end
          end
        end
        CHANGING: begin
          if (sync1[i] == out_q[i]) begin
            // Input fell back before the count completed: reject as a glitch.
            cnt_d[i]   = '0;
            state_d[i] = STABLE;
          end else if (cnt_q[i] == CNT_LAST) begin
            out_d[i]   = sync1[i];
            cnt_d[i]   = '0;
            state_d[i] = STABLE;
          end else begin
            cnt_d[i] = cnt_q[i] + 8'd1;
          end
        end
      endcase
    end
  end

  // changed lines up with the output update, so several channels flipping together give one pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      changed_q   <= 1'b0;
      settled_q   <= 1'b0;
      start_cnt_q <= '0;
    end else begin
      changed_q <= |(out_d ^ out_q);
      if (!settled_q) begin
        if (start_cnt_q == SETTLE_LAST) settled_q <= 1'b1;
        else                            start_cnt_q <= start_cnt_q + 9'd1;
      end
    end
  end

  assign {b2, a2, b1, a1} = out_q;
  assign changed          = changed_q;
  assign settled          = settled_q;

endmodule
